// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared pipeline-buffer types and constants used by the data-memory arbiter.
package Pipe_Buf_Reg_PKG;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam logic [2:0]  DBG_FUNC3_WORD = 3'b010;
  localparam int unsigned ARB_LEN_W      = 2;
  localparam int unsigned ARB_WAIT_W     = 4;

  // Beats-remaining counter holds beats minus one, so zero marks the final beat.
  function automatic logic is_last_beat(input logic [ARB_LEN_W-1:0] rem);
    return (rem == '0);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of debug cycles denied a memory slot; o_hit flags MAX_WAIT.
module arb_wait_counter
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_hit
);

  localparam logic [ARB_WAIT_W-1:0] LP_MAX = ARB_WAIT_W'(MAX_WAIT);

  logic [ARB_WAIT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LP_MAX)) begin
      r_cnt <= r_cnt + ARB_WAIT_W'(1);
    end
  end

  assign o_hit = (r_cnt == LP_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and a debug burst port.
// Define DMEM_ARB_STARVE_GUARD_EN to let a starved debug beat stall the pipeline.
module dmem_arbiter
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int unsigned DM_ADDRESS = 9,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic                  core_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [1:0]            dbg_len,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_ack,
  output logic                  dbg_last,
  output logic                  dbg_busy,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  dbg_rvalid,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  if ((MAX_WAIT < 1) || (MAX_WAIT > 15)) begin : g_bad_max_wait
    $error("dmem_arbiter: MAX_WAIT must be in 1..15");
  end

  arb_state_t            r_state, w_state_nxt;
  logic [DM_ADDRESS-1:0] r_addr, w_addr_nxt;
  logic [ARB_LEN_W-1:0]  r_rem, w_rem_nxt;
  logic                  r_we, w_we_nxt;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_rvalid;
  logic                  w_core_req;
  logic                  w_grant;
  logic                  w_force;

  assign w_core_req = core_rd | core_wr;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  logic w_hit;
  logic w_wait_clr;
  logic w_wait_inc;

  assign w_wait_clr = (r_state != BURST) || w_grant;
  assign w_wait_inc = (r_state == BURST) && !w_grant;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_wait_clr),
    .i_inc (w_wait_inc),
    .o_hit (w_hit)
  );

  assign w_force = w_hit;
`else
  assign w_force = 1'b0;
`endif

  // State and burst bookkeeping registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_addr   <= '0;
      r_rem    <= '0;
      r_we     <= 1'b0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_addr   <= w_addr_nxt;
      r_rem    <= w_rem_nxt;
      r_we     <= w_we_nxt;
      r_rvalid <= w_grant && !r_we;
      if (w_grant && !r_we) begin
        r_rdata <= mem_rdata;
      end
    end
  end

  // Next state and memory-port steering; the core owns the port unless a beat is granted.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_we_nxt    = r_we;
    w_grant     = 1'b0;
    mem_rd      = core_rd;
    mem_wr      = core_wr;
    mem_addr    = core_addr;
    mem_wdata   = core_wdata;
    mem_func3   = core_func3;
    dbg_ack     = 1'b0;
    dbg_last    = 1'b0;
    core_stall  = 1'b0;

    case (r_state)
      IDLE: begin
        if (dbg_req) begin
          w_state_nxt = BURST;
          w_we_nxt    = dbg_we;
          w_addr_nxt  = dbg_addr;
          w_rem_nxt   = dbg_len;
        end
      end
      BURST: begin
        if (!w_core_req || w_force) begin
          w_grant    = 1'b1;
          mem_rd     = !r_we;
          mem_wr     = r_we;
          mem_addr   = r_addr;
          mem_wdata  = dbg_wdata;
          mem_func3  = DBG_FUNC3_WORD;
          dbg_ack    = 1'b1;
          dbg_last   = is_last_beat(r_rem);
          core_stall = w_core_req;
          w_addr_nxt = r_addr + DM_ADDRESS'(4);
          w_rem_nxt  = r_rem - ARB_LEN_W'(1);
          if (is_last_beat(r_rem)) begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign dbg_busy   = (r_state == BURST);
  assign dbg_rdata  = r_rdata;
  assign dbg_rvalid = r_rvalid;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter; expected beats are queued as stimulus is issued.
module tb_dmem_arbiter;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 32;
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          core_rd, core_wr;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [2:0]    core_func3;
  logic          core_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [1:0]    dbg_len;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack, dbg_last, dbg_busy, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    mem_func3;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3), .core_stall(core_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_last(dbg_last),
    .dbg_busy(dbg_busy), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  // Word-addressed memory model, combinational read.
  logic [DW-1:0] mem [0:127];
  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wr;
    logic          last;
    logic [DW-1:0] data;
    logic          stall;
  } exp_ack_t;

  exp_ack_t      q_ack[$];
  logic [DW-1:0] q_rd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic void exp_beat(input logic [AW-1:0] a, input logic wr, input logic last,
                                   input logic [DW-1:0] d, input logic stall);
    exp_ack_t e;
    e.addr = a; e.wr = wr; e.last = last; e.data = d; e.stall = stall;
    q_ack.push_back(e);
    if (!wr) q_rd.push_back(d);
  endfunction

  // Monitor: pops expectations whenever the DUT acks a beat or presents read data.
  logic prev_rd = 1'b0;
  always @(negedge clk) begin
    exp_ack_t e;
    logic [DW-1:0] ed;
    if (!reset) begin
      prev_rd = 1'b0;
    end else begin
      if (dbg_ack) begin
        if (q_ack.size() == 0) begin
          flag("unexpected_ack");
        end else begin
          e = q_ack.pop_front();
          chk("ack_addr", 32'(mem_addr), 32'(e.addr));
          chk("ack_dir", {30'b0, mem_wr, mem_rd}, {30'b0, e.wr, ~e.wr});
          chk("ack_last", 32'(dbg_last), 32'(e.last));
          chk("ack_stall", 32'(core_stall), 32'(e.stall));
          chk("ack_func3", 32'(mem_func3), 32'h2);
          if (e.wr) chk("ack_wdata", mem_wdata, e.data);
        end
      end
      if (dbg_rvalid) begin
        if (!prev_rd) flag("rvalid_without_read_ack");
        if (q_rd.size() == 0) begin
          flag("unexpected_rvalid");
        end else begin
          ed = q_rd.pop_front();
          chk("rdata", dbg_rdata, ed);
        end
      end else if (prev_rd) begin
        flag("rvalid_missing");
      end
      prev_rd = dbg_ack && mem_rd;
    end
  end

  task automatic core_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    core_wr = 1'b1; core_addr = a; core_wdata = d; core_func3 = 3'b010;
    step();
    core_wr = 1'b0;
  endtask

  task automatic dbg_burst(input logic we, input logic [AW-1:0] a, input logic [1:0] len,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                           output int cycles);
    logic [DW-1:0] d [4];
    int beat;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    for (int i = 0; i <= int'(len); i++)
      exp_beat(a + 9'(4 * i), we, (i == int'(len)), d[i], 1'b0);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_len = len; dbg_wdata = d[0];
    step();
    dbg_req = 1'b0;
    beat = 0;
    cycles = 0;
    while (beat <= int'(len) && cycles < 40) begin
      dbg_wdata = d[beat];
      @(negedge clk);
      if (dbg_ack) beat++;
      step();
      cycles++;
    end
    if (beat <= int'(len)) flag("burst_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic exp_ack;
    core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_func3 = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_len = '0; dbg_wdata = '0;

    // Reset state: debug side quiet, memory port follows the core.
    repeat (2) @(posedge clk);
    #1;
    core_rd = 1'b1; core_addr = 9'h044; core_func3 = 3'b100;
    @(negedge clk);
    chk("rst_busy", 32'(dbg_busy), 0);
    chk("rst_ack", 32'(dbg_ack), 0);
    chk("rst_rvalid", 32'(dbg_rvalid), 0);
    chk("rst_rdata", dbg_rdata, 0);
    chk("rst_stall", 32'(core_stall), 0);
    chk("rst_pass_rd", {30'b0, mem_wr, mem_rd}, 32'h1);
    chk("rst_pass_addr", 32'(mem_addr), 32'h044);
    chk("rst_pass_func3", 32'(mem_func3), 32'h4);
    core_rd = 1'b0;
    reset = 1'b1;
    step();

    // Preload through the core path.
    core_store(9'h1FC, 32'h1111_00FC);
    core_store(9'h000, 32'h2222_0000);
    core_store(9'h020, 32'h3333_0020);
    core_store(9'h024, 32'h4444_0024);
    core_store(9'h100, 32'hC0DE_0100);
    core_store(9'h060, 32'h0);
    core_store(9'h064, 32'h0);
    core_store(9'h068, 32'h0);
    chk("pre_store", mem[9'h100 >> 2], 32'hC0DE_0100);

    // Idle core, 4-beat write burst.
    dbg_burst(1'b1, 9'h010, 2'd3, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004, cyc);
    chk("wr4_cycles", 32'(cyc), 4);
    @(negedge clk);
    chk("wr4_idle_after", 32'(dbg_busy), 0);
    chk("wr4_mem0", mem[4], 32'hAAAA_0001);
    chk("wr4_mem1", mem[5], 32'hBBBB_0002);
    chk("wr4_mem2", mem[6], 32'hCCCC_0003);
    chk("wr4_mem3", mem[7], 32'hDDDD_0004);
    step();

    // 2-beat read burst wrapping from 0x1FC to 0x000.
    dbg_burst(1'b0, 9'h1FC, 2'd1, 32'h1111_00FC, 32'h2222_0000, 32'h0, 32'h0, cyc);
    chk("rd_wrap_cycles", 32'(cyc), 2);
    repeat (2) step();

    // Core loads every other cycle while a 2-beat read runs.
    exp_beat(9'h020, 1'b0, 1'b0, 32'h3333_0020, 1'b0);
    exp_beat(9'h024, 1'b0, 1'b1, 32'h4444_0024, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h020; dbg_len = 2'd1;
    for (int k = 0; k < 6; k++) begin
      core_rd = (k % 2 == 0); core_addr = 9'h100; core_func3 = 3'b010;
      @(negedge clk);
      if (core_rd) begin
        chk("alt_core_rd", 32'(mem_rd), 1);
        chk("alt_core_addr", 32'(mem_addr), 32'h100);
        chk("alt_core_data", mem_rdata, 32'hC0DE_0100);
        chk("alt_no_ack", 32'(dbg_ack), 0);
      end
      chk("alt_stall", 32'(core_stall), 0);
      step();
      dbg_req = 1'b0;
    end
    core_rd = 1'b0;
    chk("alt_all_beats", 32'(q_ack.size()), 0);
    step();

    // Core storing every cycle during a 1-beat debug write.
    core_wr = 1'b1; core_addr = 9'h080; core_wdata = 32'h5555_0080; core_func3 = 3'b010;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h040; dbg_len = 2'd0; dbg_wdata = 32'h7777_0040;
    if (GUARD) exp_beat(9'h040, 1'b1, 1'b1, 32'h7777_0040, 1'b1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        exp_ack = GUARD && (k == 5);
        chk("busy_ack", 32'(dbg_ack), 32'(exp_ack));
        chk("busy_stall", 32'(core_stall), 32'(exp_ack));
        if (!exp_ack) chk("busy_core_wins", {mem_wr, 22'b0, mem_addr}, {1'b1, 22'b0, 9'h080});
        if (GUARD && k == 6) chk("guard_done", 32'(dbg_busy), 0);
      end
      step();
      dbg_req = 1'b0;
    end
    core_wr = 1'b0;
    if (!GUARD) begin
      exp_beat(9'h040, 1'b1, 1'b1, 32'h7777_0040, 1'b0);
      @(negedge clk);
      chk("freed_ack", 32'(dbg_ack), 1);
      step();
    end
    @(negedge clk);
    chk("busy_end_idle", 32'(dbg_busy), 0);
    chk("busy_dbg_mem", mem[9'h040 >> 2], 32'h7777_0040);
    chk("busy_core_mem", mem[9'h080 >> 2], 32'h5555_0080);
    step();

    // Reset during beat 2 of a 4-beat write.
    exp_beat(9'h060, 1'b1, 1'b0, 32'hE000_0000, 1'b0);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h060; dbg_len = 2'd3; dbg_wdata = 32'hE000_0000;
    step();
    dbg_req = 1'b0;
    step();
    dbg_wdata = 32'hE111_1111;
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(dbg_busy), 0);
    chk("rst_mid_ack", 32'(dbg_ack), 0);
    chk("rst_mid_memwr", 32'(mem_wr), 0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdata", dbg_rdata, 0);
    chk("rst_mid_rvalid", 32'(dbg_rvalid), 0);
    repeat (6) step();
    chk("rst_after_busy", 32'(dbg_busy), 0);
    chk("rst_beat1_mem", mem[9'h060 >> 2], 32'hE000_0000);
    chk("rst_beat2_mem", mem[9'h064 >> 2], 32'h0);
    chk("rst_beat3_mem", mem[9'h068 >> 2], 32'h0);

    chk("ack_queue_empty", 32'(q_ack.size()), 0);
    chk("rd_queue_empty", 32'(q_rd.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
